// File: rtl/uart_pkg.sv
// Shared types for the configurable UART core: parity modes,
// TX/RX state encodings and the parity helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } par_mode_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Zero-extension to 8 bits leaves both XOR and XNOR reductions intact.
  function automatic logic par_calc(input logic [1:0] mode,
                                    input logic [7:0] d);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; writes when full and
// reads when empty are ignored.
module uart_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, rptr_q;
  logic [CW-1:0]         cnt_q;
  logic                  we, re;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign we      = wr_i & ~full_o;
  assign re      = rd_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (we) wptr_q <= wptr_q + ADDR_WIDTH'(1);
      if (re) rptr_q <= rptr_q + ADDR_WIDTH'(1);
      if (we && !re)      cnt_q <= cnt_q + CW'(1);
      else if (re && !we) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_core_cfg.sv
// Runtime-configurable UART core with TX/RX FIFOs and sticky errors.
// Parity support is compiled in only when UART_PARITY_EN is defined.
module uart_core_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVER_SAMPLE = 16,
  parameter int DIV_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic                 wr_uart,
  input  logic [DATA_BITS-1:0] w_data,
  output logic                 tx_full,
  output logic                 tx_busy,
  input  logic                 rd_uart,
  output logic [DATA_BITS-1:0] r_data,
  output logic                 rx_empty,
  input  logic                 err_clr,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  input  logic                 rx,
  output logic                 tx
);

  localparam int TW = $clog2(OVER_SAMPLE);
  localparam logic [TW-1:0] T_LAST = TW'(OVER_SAMPLE - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVER_SAMPLE / 2 - 1);
  localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 tick;
  logic                 par_en;

  assign tick  = (div_q >= baud_div);
  assign div_d = tick ? '0 : div_q + DIV_WIDTH'(1);

  // TX datapath
  tx_state_e            txs_q, txs_d;
  logic [TW-1:0]        txt_q, txt_d;
  logic [2:0]           txb_q, txb_d;
  logic [DATA_BITS-1:0] txsh_q, txsh_d;
  logic                 txp_q, txp_d;
  logic                 tx_pop, tx_empty, tx_end;
  logic [DATA_BITS-1:0] tx_dout;

  // RX datapath
  rx_state_e            rxs_q, rxs_d;
  logic [TW-1:0]        rxt_q, rxt_d;
  logic [2:0]           rxb_q, rxb_d;
  logic [DATA_BITS-1:0] rxsh_q, rxsh_d;
  logic                 rxp_q, rxp_d;
  logic [1:0]           sync_q;
  logic                 rx_s, rx_end, rx_push, rx_full;
  logic                 frame_set, ovr_set, par_set;
  logic                 ferr_q, oerr_q;

  assign rx_s   = sync_q[1];
  assign tx_end = tick && (txt_q == T_LAST);
  assign rx_end = tick &&
                  (rxt_q == ((rxs_q == RX_START) ? T_HALF : T_LAST));

  always_comb begin
    txs_d  = txs_q;
    txt_d  = txt_q;
    txb_d  = txb_q;
    txsh_d = txsh_q;
    txp_d  = txp_q;
    tx_pop = 1'b0;
    if (txs_q != TX_IDLE && tick)
      txt_d = tx_end ? '0 : txt_q + TW'(1);
    unique case (txs_q)
      TX_IDLE: if (!tx_empty) begin
        tx_pop = 1'b1;
        txsh_d = tx_dout;
        txp_d  = par_calc(parity_mode, 8'(tx_dout));
        txt_d  = '0;
        txs_d  = TX_START;
      end
      TX_START: if (tx_end) begin
        txb_d = '0;
        txs_d = TX_DATA;
      end
      TX_DATA: if (tx_end) begin
        txsh_d = txsh_q >> 1;
        txb_d  = txb_q + 3'd1;
        if (txb_q == B_LAST) begin
          txb_d = '0;
          txs_d = par_en ? TX_PARITY : TX_STOP;
        end
      end
      TX_PARITY: if (tx_end) txs_d = TX_STOP;
      TX_STOP: if (tx_end) begin
        if (stop2 && txb_q == '0) txb_d = 3'd1;
        else                      txs_d = TX_IDLE;
      end
      default: txs_d = TX_IDLE;
    endcase
  end

  assign tx = (txs_q == TX_START)  ? 1'b0 :
              (txs_q == TX_DATA)   ? txsh_q[0] :
              (txs_q == TX_PARITY) ? txp_q : 1'b1;
  assign tx_busy = (txs_q != TX_IDLE);

  always_comb begin
    rxs_d     = rxs_q;
    rxt_d     = rxt_q;
    rxb_d     = rxb_q;
    rxsh_d    = rxsh_q;
    rxp_d     = rxp_q;
    rx_push   = 1'b0;
    frame_set = 1'b0;
    if (rxs_q != RX_IDLE && tick)
      rxt_d = rx_end ? '0 : rxt_q + TW'(1);
    unique case (rxs_q)
      RX_IDLE: if (!rx_s) begin
        rxt_d = '0;
        rxs_d = RX_START;
      end
      // A start bit that is high again at mid-bit was only a glitch.
      RX_START: if (rx_end) begin
        rxb_d = '0;
        rxs_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_end) begin
        rxsh_d = {rx_s, rxsh_q[DATA_BITS-1:1]};
        rxb_d  = rxb_q + 3'd1;
        if (rxb_q == B_LAST)
          rxs_d = par_en ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_end) begin
        rxp_d = rx_s;
        rxs_d = RX_STOP;
      end
      RX_STOP: if (rx_end) begin
        rxs_d     = RX_IDLE;
        rx_push   = rx_s;
        frame_set = ~rx_s;
      end
      default: rxs_d = RX_IDLE;
    endcase
  end

  assign ovr_set = rx_push & rx_full;
  assign par_set = rx_push & par_en &
                   (rxp_q != par_calc(parity_mode, 8'(rxsh_q)));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      txs_q  <= TX_IDLE;
      txt_q  <= '0;
      txb_q  <= '0;
      txsh_q <= '0;
      txp_q  <= 1'b0;
      rxs_q  <= RX_IDLE;
      rxt_q  <= '0;
      rxb_q  <= '0;
      rxsh_q <= '0;
      rxp_q  <= 1'b0;
      sync_q <= 2'b11;
      ferr_q <= 1'b0;
      oerr_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      txs_q  <= txs_d;
      txt_q  <= txt_d;
      txb_q  <= txb_d;
      txsh_q <= txsh_d;
      txp_q  <= txp_d;
      rxs_q  <= rxs_d;
      rxt_q  <= rxt_d;
      rxb_q  <= rxb_d;
      rxsh_q <= rxsh_d;
      rxp_q  <= rxp_d;
      sync_q <= {sync_q[0], rx};
      ferr_q <= frame_set | (ferr_q & ~err_clr);
      oerr_q <= ovr_set | (oerr_q & ~err_clr);
    end
  end

  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;

`ifdef UART_PARITY_EN
  logic perr_q;

  assign par_en = (parity_mode == PAR_EVEN) ||
                  (parity_mode == PAR_ODD);

  always_ff @(posedge clk) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= par_set | (perr_q & ~err_clr);
  end

  assign parity_err = perr_q;
`else
  logic unused_par;

  assign par_en     = 1'b0;
  assign parity_err = 1'b0;
  assign unused_par = par_set;
`endif

  uart_fifo #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_BITS)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .wr_i    (wr_uart),
    .wdata_i (w_data),
    .rd_i    (tx_pop),
    .rdata_o (tx_dout),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  uart_fifo #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_BITS)
  ) u_rx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .wr_i    (rx_push),
    .wdata_i (rxsh_q),
    .rd_i    (rd_uart),
    .rdata_o (r_data),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

endmodule

// File: doc/uart_core_cfg.md
# uart_core_cfg

Runtime-configurable UART core: next generation of the fixed 8N1 UART top. Adds a programmable baud divisor, 5–8 data bits, optional parity, 1 or 2 stop bits, sticky RX error flags and parameterised TX/RX FIFOs. Sits between the bus-side register block (FIFO push/pop, config, error clear) and the device pins `rx`/`tx`.

## Interface
- `DATA_BITS`, 8, data bits per frame, legal 5..8
- `OVER_SAMPLE`, 16, ticks per bit, even, ≥ 8
- `DIV_WIDTH`, 16, width of `baud_div`
- `ADDR_WIDTH`, 4, FIFO depth = 2**ADDR_WIDTH per direction
- `clk` in 1: single clock; all logic rising-edge
- `rst` in 1: synchronous, active-high reset
- `baud_div` in DIV_WIDTH: tick period minus 1, in `clk` cycles
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 none
- `stop2` in 1: 1 = two TX stop bits
- `wr_uart` in 1 / `w_data` in DATA_BITS: TX FIFO push
- `tx_full` out 1, `tx_busy` out 1
- `rd_uart` in 1 / `r_data` out DATA_BITS: RX FIFO pop, first-word-fall-through
- `rx_empty` out 1
- `err_clr` in 1: clears all error flags
- `frame_err`, `parity_err`, `overrun_err` out 1 each: sticky
- `rx` in 1, `tx` out 1

## Operation
- Tick generator: counter 0..`baud_div`; one-cycle `tick` when counter == `baud_div`, then counter → 0. Counter ≥ `baud_div` (divisor lowered) also wraps. `baud_div`=0 → tick every cycle.
- TX FSM IDLE→START→DATA→PARITY→STOP→IDLE. Each state lasts OVER_SAMPLE ticks per bit; DATA LSB first, DATA_BITS bits; PARITY skipped when none; STOP one or two bits per `stop2`. IDLE with TX FIFO non-empty: pop and latch word same cycle, go START. `tx`=1 in IDLE/STOP, 0 in START. `tx_busy`=1 outside IDLE.
- RX: `rx` through 2-flop synchroniser. IDLE: synced low → START. START: after OVER_SAMPLE/2 ticks, low → DATA, high → IDLE (glitch, no flags). DATA/PARITY/STOP: sample every OVER_SAMPLE ticks (mid-bit). Only first stop bit checked.
- At stop sample: stop low → `frame_err` set, word discarded. Else push word; parity mismatch → `parity_err` set, word still pushed. RX FIFO full → word dropped, `overrun_err` set.
- Error flags: set has priority over `err_clr` in the same cycle.
- Config inputs are sampled continuously; changes mid-frame are illegal (result undefined, no lock-up).
- FIFOs: write when full dropped (even with simultaneous read); read when empty ignored; otherwise simultaneous read+write both occur, count unchanged. Pointers wrap modulo depth.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `tx_full`=0, `rx_empty`=1, all error flags 0, `r_data`=0, FSMs IDLE, tick counter 0, FIFOs empty.
- `rst` mid-frame: next cycle `tx`=1, frame abandoned, both FIFOs emptied.
- `wr_uart` at cycle N into empty FIFO, idle TX: pop at N+1, `tx`=0 and `tx_busy`=1 from N+2.
- Frame length = (1 + DATA_BITS + parity + 1 + stop2) × OVER_SAMPLE × (`baud_div`+1) cycles.
- RX word visible on `r_data`, `rx_empty`=0, the cycle after the stop-bit sample; flags update the same cycle.

## Configuration
- `UART_PARITY_EN` defined: parity generation/check and PARITY states compiled in.
- Undefined: `parity_mode` port kept but ignored, frames have no parity bit, `parity_err` tied 0.

## Structure
- Package `uart_pkg`: parity-mode enum, TX and RX state enums, constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`.
- Sub-module `uart_fifo` (sync FWFT, params ADDR_WIDTH/DATA_WIDTH), instantiated twice; tick generator, TX and RX FSMs inline.

## Test plan
- `baud_div`=3, OVER_SAMPLE=16, 8N1, write 0xA5 → `tx` low 64 cycles, bits 1,0,1,0,0,1,0,1 at 64 cycles each, stop high; `tx_busy` falls after 640 cycles.
- Loopback `tx`→`rx`, even parity, `stop2`=1, send 0x00,0xFF,0x3C → read back same order, no errors.
- Drive frame with stop bit 0 → `frame_err`=1, `rx_empty` stays 1; `err_clr` → flag 0 next cycle.
- Odd parity configured, inject even-parity frame 0x55 → word 0x55 read, `parity_err`=1.
- ADDR_WIDTH=2: receive 5 words without reading → 4 stored, `overrun_err`=1; write 5 to TX with TX stalled by long frame → `tx_full`=1, 5th dropped.
- 2-cycle low glitch on `rx` → no push, no flags; `rst` mid-TX → `tx`=1 next cycle, `tx_full`=0, `rx_empty`=1.
